// File: rtl/muldiv_ctrl_pkg.sv
// Shared M-extension definitions: funct3 selector codes and controller state encoding.
package muldiv_ctrl_pkg;

  localparam logic [2:0] F3Mul    = 3'b000;
  localparam logic [2:0] F3Mulh   = 3'b001;
  localparam logic [2:0] F3Mulhsu = 3'b010;
  localparam logic [2:0] F3Mulhu  = 3'b011;
  localparam logic [2:0] F3Div    = 3'b100;
  localparam logic [2:0] F3Divu   = 3'b101;
  localparam logic [2:0] F3Rem    = 3'b110;
  localparam logic [2:0] F3Remu   = 3'b111;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StWait  = 3'd2,
    StDone  = 3'd3,
    StDrain = 3'd4
  } state_e;

  function automatic logic is_div_op(input logic [2:0] funct3);
    return funct3[2];
  endfunction

  function automatic logic is_rem_op(input logic [2:0] funct3);
    return funct3[2] & funct3[1];
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Issue/sequencing controller for the multiply/divide unit: latch, start, wait, writeback.
// Optional divide-by-zero bypass is enabled with `define M_DIV_ZERO_BYPASS_EN.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned RD_W = 5
) (
  input  logic            i_clk_n,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [31:0]     i_op_a,
  input  logic [31:0]     i_op_b,
  input  logic [2:0]      i_funct3,
  input  logic [RD_W-1:0] i_rd,
  input  logic            i_flush,
  output logic            o_ready,
  output logic            o_stall,
  output logic [31:0]     o_md_a,
  output logic [31:0]     o_md_b,
  output logic [2:0]      o_md_funct3,
  output logic            o_md_en,
  input  logic [31:0]     i_md_result,
  input  logic            i_md_busy,
  output logic            o_wb_valid,
  output logic [RD_W-1:0] o_wb_rd,
  output logic [31:0]     o_wb_data,
  input  logic            i_wb_ready
);

  state_e            state_q, state_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [2:0]        f3_q, f3_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [31:0]       data_q, data_d;
  logic              ready;
  logic              md_en;
  logic              wb_valid;

  always_ff @(posedge i_clk_n) begin
    if (i_rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    data_d   = data_q;
    ready    = 1'b0;
    md_en    = 1'b0;
    wb_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (i_valid && !i_flush) begin
          a_d     = i_op_a;
          b_d     = i_op_b;
          f3_d    = i_funct3;
          rd_d    = i_rd;
          state_d = StStart;
`ifdef M_DIV_ZERO_BYPASS_EN
          // Architectural divide-by-zero results without touching the unit.
          if (is_div_op(i_funct3) && (i_op_b == 32'd0)) begin
            data_d  = is_rem_op(i_funct3) ? i_op_a : 32'hFFFF_FFFF;
            state_d = StDone;
          end
`endif
        end
      end
      StStart: begin
        md_en   = !i_flush;
        state_d = i_flush ? StIdle : StWait;
      end
      StWait: begin
        if (i_flush) begin
          state_d = StDrain;
        end else if (!i_md_busy) begin
          data_d  = i_md_result;
          state_d = StDone;
        end
      end
      StDone: begin
        // Flush masks valid so a coincident ready cannot complete a handshake.
        wb_valid = !i_flush;
        if (i_flush || i_wb_ready) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (!i_md_busy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign o_ready     = ready;
  assign o_stall     = !ready;
  assign o_md_en     = md_en;
  assign o_md_a      = a_q;
  assign o_md_b      = b_q;
  assign o_md_funct3 = f3_q;
  assign o_wb_valid  = wb_valid;
  assign o_wb_rd     = rd_q;
  assign o_wb_data   = data_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a behavioural multiply/divide unit alongside.
`timescale 1ns/1ps
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int unsigned RdW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_valid;
  logic [31:0]     i_op_a;
  logic [31:0]     i_op_b;
  logic [2:0]      i_funct3;
  logic [RdW-1:0]  i_rd;
  logic            i_flush;
  logic            o_ready;
  logic            o_stall;
  logic [31:0]     o_md_a;
  logic [31:0]     o_md_b;
  logic [2:0]      o_md_funct3;
  logic            o_md_en;
  logic [31:0]     md_result;
  logic            md_busy;
  logic            o_wb_valid;
  logic [RdW-1:0]  o_wb_rd;
  logic [31:0]     o_wb_data;
  logic            i_wb_ready;

  int total = 0;
  int bad   = 0;
  int en_cnt = 0;
  int en_busy_cnt = 0;
  int unsigned busy_cnt = 0;
  logic mul_fast = 1'b1;

  always #5 clk = ~clk;

  muldiv_ctrl #(.RD_W(RdW)) dut (
    .i_clk_n     (clk),
    .i_rst       (rst),
    .i_valid     (i_valid),
    .i_op_a      (i_op_a),
    .i_op_b      (i_op_b),
    .i_funct3    (i_funct3),
    .i_rd        (i_rd),
    .i_flush     (i_flush),
    .o_ready     (o_ready),
    .o_stall     (o_stall),
    .o_md_a      (o_md_a),
    .o_md_b      (o_md_b),
    .o_md_funct3 (o_md_funct3),
    .o_md_en     (o_md_en),
    .i_md_result (md_result),
    .i_md_busy   (md_busy),
    .o_wb_valid  (o_wb_valid),
    .o_wb_rd     (o_wb_rd),
    .o_wb_data   (o_wb_data),
    .i_wb_ready  (i_wb_ready)
  );

  // Unit model: busy count set on the enable edge, result combinational on held operands.
  function automatic int unsigned unit_cycles(input logic [2:0] f3, input logic [31:0] b,
                                              input logic fast);
    logic [31:0] mag;
    if (f3[2]) return 32;
    if (fast) return 0;
    mag = (!f3[1] && b[31]) ? -b : b;
    for (int i = 31; i >= 0; i--) begin
      if (mag[i]) return i + 1;
    end
    return 0;
  endfunction

  function automatic logic [31:0] unit_result(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
    logic [63:0] p;
    logic sa, sb;
    logic [31:0] ma, mb, q, r;
    if (!f3[2]) begin
      sa = (f3 != F3Mulhu) & a[31];
      sb = (f3 == F3Mul || f3 == F3Mulh) & b[31];
      p  = {{32{sa}}, a} * {{32{sb}}, b};
      return (f3 == F3Mul) ? p[31:0] : p[63:32];
    end
    sa = !f3[0] & a[31];
    sb = !f3[0] & b[31];
    ma = sa ? -a : a;
    mb = sb ? -b : b;
    if (mb == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = ma;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (f3[1]) return sa ? -r : r;
    return (sa ^ sb) ? -q : q;
  endfunction

  always @(posedge clk) begin
    if (o_md_en) en_cnt++;
    if (o_md_en && md_busy) en_busy_cnt++;
    if (rst) busy_cnt <= 0;
    else if (o_md_en) busy_cnt <= unit_cycles(o_md_funct3, o_md_b, mul_fast);
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  assign md_busy = (busy_cnt != 0);
  always_comb md_result = unit_result(o_md_funct3, o_md_a, o_md_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge, then follow it to DONE; handshake if i_wb_ready is high.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [RdW-1:0] rd,
                        input logic [31:0] exp_data, input int exp_lat, input int exp_en);
    int cyc;
    int stall_lo;
    int en0;
    en0 = en_cnt;
    chk({tag, "/ready_before"}, {31'd0, o_ready}, 32'd1);
    i_valid = 1'b1;
    i_funct3 = f3;
    i_op_a = a;
    i_op_b = b;
    i_rd = rd;
    @(negedge clk);
    i_valid = 1'b0;
    cyc = 1;
    stall_lo = 0;
    while (!o_wb_valid && cyc < 200) begin
      if (!o_stall) stall_lo++;
      @(negedge clk);
      cyc++;
    end
    if (!o_stall) stall_lo++;
    chk({tag, "/latency"}, cyc, exp_lat);
    chk({tag, "/data"}, o_wb_data, exp_data);
    chk({tag, "/rd"}, {27'd0, o_wb_rd}, {27'd0, rd});
    chk({tag, "/stall_low_cycles"}, stall_lo, 0);
    chk({tag, "/md_en_pulses"}, en_cnt - en0, exp_en);
    chk({tag, "/md_a_held"}, o_md_a, a);
    if (i_wb_ready) begin
      @(negedge clk);
      chk({tag, "/ready_after"}, {31'd0, o_ready}, 32'd1);
      chk({tag, "/valid_after"}, {31'd0, o_wb_valid}, 32'd0);
    end
  endtask

  initial begin
    int cyc;
    logic seen;
    logic [31:0] held_data;
    rst = 1'b1;
    i_valid = 1'b0;
    i_op_a = '0;
    i_op_b = '0;
    i_funct3 = '0;
    i_rd = '0;
    i_flush = 1'b0;
    i_wb_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("reset/ready", {31'd0, o_ready}, 32'd1);
    chk("reset/stall", {31'd0, o_stall}, 32'd0);
    chk("reset/wb_valid", {31'd0, o_wb_valid}, 32'd0);
    chk("reset/md_a", o_md_a, 32'd0);
    chk("reset/wb_data", o_wb_data, 32'd0);

    run_op("divu", F3Divu, 32'd100, 32'd7, 5'd3, 32'd14, 35, 1);
    run_op("remu", F3Remu, 32'd100, 32'd7, 5'd4, 32'd2, 35, 1);
    run_op("rem_neg", F3Rem, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, 35, 1);
    run_op("div_ovf", F3Div, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000, 35, 1);
    run_op("mul_fast", F3Mul, 32'd6, 32'd7, 5'd7, 32'd42, 3, 1);
    mul_fast = 1'b0;
    run_op("mulhu_sa", F3Mulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFE, 35, 1);
    run_op("mul_sa_k3", F3Mul, 32'd6, 32'd7, 5'd9, 32'd42, 6, 1);
    run_op("mul_b0", F3Mul, 32'd1234, 32'd0, 5'd10, 32'd0, 3, 1);
    mul_fast = 1'b1;

`ifdef M_DIV_ZERO_BYPASS_EN
    run_op("div_by0", F3Div, 32'hFFFF_FFF9, 32'd0, 5'd11, 32'hFFFF_FFFF, 1, 0);
    run_op("remu_by0", F3Remu, 32'd77, 32'd0, 5'd12, 32'd77, 1, 0);
`else
    run_op("div_by0", F3Div, 32'hFFFF_FFF9, 32'd0, 5'd11, 32'h0000_0001, 35, 1);
`endif

    // Flush in the 10th WAIT cycle of a divide.
    i_valid = 1'b1;
    i_funct3 = F3Divu;
    i_op_a = 32'd100;
    i_op_b = 32'd7;
    i_rd = 5'd13;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (10) @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    cyc = 12;
    seen = 1'b0;
    while (!o_ready && cyc < 200) begin
      if (o_wb_valid) seen = 1'b1;
      @(negedge clk);
      cyc++;
    end
    chk("drain/ready_cycle", cyc, 35);
    chk("drain/no_wb_valid", {31'd0, seen}, 32'd0);
    run_op("mul_after_drain", F3Mul, 32'd3, 32'd5, 5'd14, 32'd15, 3, 1);

    // Writeback back-pressure: outputs must stay put.
    i_wb_ready = 1'b0;
    run_op("hold", F3Mul, 32'd9, 32'd9, 5'd15, 32'd81, 3, 1);
    held_data = o_wb_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold/valid", {31'd0, o_wb_valid}, 32'd1);
      chk("hold/rd", {27'd0, o_wb_rd}, 32'd15);
      chk("hold/data", o_wb_data, held_data);
    end
    i_wb_ready = 1'b1;
    @(negedge clk);
    chk("hold/ready_after", {31'd0, o_ready}, 32'd1);

    // Flush and ready together in DONE: no handshake.
    i_wb_ready = 1'b0;
    run_op("done_flush", F3Mul, 32'd2, 32'd8, 5'd16, 32'd16, 3, 1);
    i_flush = 1'b1;
    i_wb_ready = 1'b1;
    #1;
    chk("done_flush/valid_masked", {31'd0, o_wb_valid}, 32'd0);
    @(negedge clk);
    i_flush = 1'b0;
    chk("done_flush/ready", {31'd0, o_ready}, 32'd1);

    // Flush in IDLE: op not accepted.
    i_valid = 1'b1;
    i_flush = 1'b1;
    i_funct3 = F3Mul;
    i_op_a = 32'hDEAD;
    @(negedge clk);
    i_valid = 1'b0;
    i_flush = 1'b0;
    chk("idle_flush/ready", {31'd0, o_ready}, 32'd1);
    chk("idle_flush/md_a_unchanged", o_md_a, 32'd2);

    // Flush in START: enable suppressed.
    i_valid = 1'b1;
    i_funct3 = F3Divu;
    i_op_a = 32'd50;
    i_op_b = 32'd5;
    @(negedge clk);
    i_valid = 1'b0;
    i_flush = 1'b1;
    #1;
    chk("start_flush/md_en", {31'd0, o_md_en}, 32'd0);
    @(negedge clk);
    i_flush = 1'b0;
    chk("start_flush/ready", {31'd0, o_ready}, 32'd1);
    chk("start_flush/busy", {31'd0, md_busy}, 32'd0);

    // Reset in the middle of WAIT.
    i_valid = 1'b1;
    i_funct3 = F3Divu;
    i_op_a = 32'd100;
    i_op_b = 32'd7;
    i_rd = 5'd17;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wait/ready", {31'd0, o_ready}, 32'd1);
    chk("rst_wait/stall", {31'd0, o_stall}, 32'd0);
    chk("rst_wait/md_en", {31'd0, o_md_en}, 32'd0);
    chk("rst_wait/wb_valid", {31'd0, o_wb_valid}, 32'd0);
    chk("rst_wait/md_a", o_md_a, 32'd0);
    chk("rst_wait/md_b", o_md_b, 32'd0);
    chk("rst_wait/md_funct3", {29'd0, o_md_funct3}, 32'd0);
    chk("rst_wait/wb_rd", {27'd0, o_wb_rd}, 32'd0);
    chk("rst_wait/wb_data", o_wb_data, 32'd0);
    run_op("after_rst", F3Remu, 32'd100, 32'd7, 5'd18, 32'd2, 35, 1);

    chk("md_en_while_busy", en_busy_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Issue/sequencing controller directly upstream of the M-extension multiply/divide unit in the execute stage. It accepts one M-op from execute, latches operands, pulses the unit's enable, and holds operands and funct3 stable for the whole operation. The unit's sign post-processing is combinational on them, so they must not change. It waits on busy, captures the result, and presents it to writeback with a valid/ready handshake; it also stalls the pipeline and handles flushes.

Parameters:
RD_W, 5, destination register index width

Ports:
i_clk_n  in  1  clock, posedge active
i_rst  in  1  synchronous active-high reset
i_valid  in  1  execute presents an M-op (funct7=0000001)
i_op_a  in  32  rs1 value
i_op_b  in  32  rs2 value
i_funct3  in  3  M-op selector (000 MUL … 111 REMU)
i_rd  in  RD_W  destination register
i_flush  in  1  pipeline flush; discard the in-flight op
o_ready  out  1  controller idle; op accepted when i_valid&&o_ready
o_stall  out  1  stall upstream stages; equals !o_ready
o_md_a  out  32  operand A to unit, held from latch
o_md_b  out  32  operand B to unit, held from latch
o_md_funct3  out  3  funct3 to unit, held from latch
o_md_en  out  1  single-cycle start pulse to unit
i_md_result  in  32  unit result
i_md_busy  in  1  unit busy
o_wb_valid  out  1  result valid to writeback
o_wb_rd  out  RD_W  destination register
o_wb_data  out  32  result
i_wb_ready  in  1  writeback accepts

Behaviour:
- Reset: state IDLE. o_ready=1, o_stall=0, o_md_en=0, o_wb_valid=0. o_md_a, o_md_b, o_md_funct3, o_wb_rd and o_wb_data are all 0. Reset mid-operation aborts immediately with no writeback.
- States: IDLE, START, WAIT, DONE, DRAIN.
- IDLE: o_ready=1. On i_valid&&!i_flush, latch a, b, funct3 and rd, then go to START. If i_flush is high, the op is not accepted.
- START: o_md_en=1 for exactly this cycle, then go to WAIT. If i_flush is high in this cycle, o_md_en is suppressed and the next state is IDLE.
- WAIT: busy is registered, so the first WAIT cycle already reflects the started op. If !i_md_busy, capture i_md_result into o_wb_data and go to DONE. If i_flush, go to DRAIN.
- DONE: o_wb_valid=1, with o_wb_rd and o_wb_data stable. Hold until i_wb_ready, then go to IDLE. If i_flush, drop to IDLE with no handshake.
- DRAIN: the unit cannot be aborted. Wait for !i_md_busy, discard the result, then go to IDLE. o_ready stays 0 throughout.
- o_md_a, o_md_b and o_md_funct3 change only on acceptance.
- Latency is counted from the accept edge E0 (cycle c1 = START):
  - Fast multiply and b=0 multiply: o_wb_valid in c3.
  - Shift-add multiply: c3+k, where k = index of the MSB set in |b| plus 1.
  - Divide/remainder: c35 (32 busy cycles).
- Back-to-back ops: the next accept occurs in the IDLE cycle after the handshake. There is no overlap, and o_md_en never fires while i_md_busy=1.
- Flush and i_wb_ready arriving in the same DONE cycle: flush wins, and o_wb_valid drops.

Optional Feature:
M_DIV_ZERO_BYPASS_EN
- Defined: when accepting DIV/DIVU/REM/REMU with i_op_b==0, skip the unit and go IDLE→DONE directly, so o_wb_valid is in c1 and o_md_en is never asserted.
  - DIV/DIVU result is 0xFFFFFFFF.
  - REM/REMU result is the dividend.
  - This gives RISC-V-compliant divide-by-zero results.
- Undefined: divide-by-zero goes through the unit and returns the unit's raw value. For signed DIV with a negative dividend this is non-compliant (e.g. -7/0 → 0x00000001).

Decomposition:
- Shared package/include: funct3 codes (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) and the 3-bit state encoding. Both the unit and this controller use the funct3 constants.
- No sub-module. The multiply/divide unit is a sibling instantiated by the execute stage and wired to the o_md_* and i_md_* ports.

Test Plan:
- DIVU a=100, b=7 → o_wb_data=14 in c35, o_stall=1 for c1..c35; REMU same operands → 2.
- REM a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000.
- MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE. Fast multiply → c3; shift-add → c35. MUL b=0 → 0 in c3.
- Flush in the 10th WAIT cycle of a DIVU → DRAIN, no o_wb_valid. o_ready returns 1 in the cycle after busy falls, and the next MUL 3×5 → 15.
- i_wb_ready held 0 for 5 cycles in DONE → o_wb_valid, o_wb_rd and o_wb_data stable throughout. Assert i_rst mid-WAIT → all outputs reset values next cycle.
- DIV a=0xFFFFFFF9, b=0 → with macro: 0xFFFFFFFF in c1, o_md_en never high. Without macro: 0x00000001 in c35.
